// File: rtl/press_pkg.sv
// Shared constants for the button press classifier: state encoding and
// default timing parameters.
package press_pkg;

  localparam int TICK_DIV_DEF     = 1_000_000;
  localparam int LONG_TICKS_DEF   = 100;
  localparam int DCLICK_TICKS_DEF = 30;
  localparam int TCNT_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT2     = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HOLD = 3'd4
  } state_e;

endpackage

// File: rtl/press_classifier_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, never restarted
// by button activity.
module tick_gen
  import press_pkg::*;
#(
  parameter int DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/press_classifier.sv
// Classifies a debounced button into short press, long press and double
// click, each reported as a registered one-cycle pulse.
module press_classifier
  import press_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int DCLICK_TICKS = DCLICK_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic db,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic busy
);

  localparam logic [TCNT_W-1:0] LONG_LAST   = TCNT_W'(LONG_TICKS - 1);
  localparam logic [TCNT_W-1:0] DCLICK_LAST = TCNT_W'(DCLICK_TICKS - 1);

  logic tick;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_e            state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              db_q, armed_q, armed_d;
  logic              short_q, short_d, long_q, long_d, dbl_q, dbl_d, busy_q, busy_d;
  logic              rise, fall;

  // armed_q stays low after reset until db is seen low, so a button held
  // through reset cannot masquerade as a fresh press.
  always_comb begin
    rise    = db & ~db_q & armed_q;
    fall    = ~db & db_q;
    armed_d = armed_q | ~db;
    state_d = state_q;
    tcnt_d  = tcnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;

    case (state_q)
      ST_IDLE: if (rise) state_d = ST_PRESS1;
      ST_PRESS1: begin
        if (fall) state_d = ST_WAIT2;
        else if (tick && tcnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = ST_LONG_HOLD;
        end else if (tick) tcnt_d = tcnt_q + 1'b1;
      end
      ST_WAIT2: begin
        if (rise) begin
          dbl_d   = 1'b1;
          state_d = ST_PRESS2;
        end else if (tick && tcnt_q == DCLICK_LAST) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end else if (tick) tcnt_d = tcnt_q + 1'b1;
      end
      ST_PRESS2, ST_LONG_HOLD: if (fall) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) tcnt_d = '0;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      db_q    <= 1'b0;
      armed_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      db_q    <= db;
      armed_q <= armed_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      busy_q  <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with TICK_DIV=4, LONG_TICKS=5,
// DCLICK_TICKS=3; cycle numbers count edges after reset release.
module tb_press_classifier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic db  = 1'b0;
  logic short_press, long_press, double_click, busy;

  int errors = 0;
  int checks = 0;
  int cyc_n, n_short, n_long, n_dbl, short_at, long_at, dbl_at;

  press_classifier #(.TICK_DIV(4), .LONG_TICKS(5), .DCLICK_TICKS(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .db           (db),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic clr_counts();
    n_short = 0; n_long = 0; n_dbl = 0;
    short_at = -1; long_at = -1; dbl_at = -1;
  endtask

  // Advance n edges, sampling 1 time unit after each rising edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc_n++;
      if (short_press)  begin n_short++; if (short_at < 0) short_at = cyc_n; end
      if (long_press)   begin n_long++;  if (long_at  < 0) long_at  = cyc_n; end
      if (double_click) begin n_dbl++;   if (dbl_at   < 0) dbl_at   = cyc_n; end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; db = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc_n = 0;
    clr_counts();
  endtask

  task automatic test_reset();
    rst = 1'b1; db = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (short_press !== 1'b0) begin errors++; $display("FAIL reset_short: got %b want 0", short_press); end
    checks++; if (long_press !== 1'b0) begin errors++; $display("FAIL reset_long: got %b want 0", long_press); end
    checks++; if (double_click !== 1'b0) begin errors++; $display("FAIL reset_dbl: got %b want 0", double_click); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_short();
    apply_reset();
    cyc(1); db = 1'b1;
    cyc(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL short_busy_on: got %b want 1", busy); end
    cyc(7); db = 1'b0;
    cyc(20);
    checks++; if (n_short !== 1) begin errors++; $display("FAIL short_count: got %0d want 1", n_short); end
    checks++; if (n_long + n_dbl !== 0) begin errors++; $display("FAIL short_other: got %0d want 0", n_long + n_dbl); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy_off: got %b want 0", busy); end
  endtask

  task automatic test_long();
    int rise_at;
    apply_reset();
    cyc(1); db = 1'b1; rise_at = cyc_n + 1;
    cyc(30); db = 1'b0;
    cyc(15);
    checks++; if (n_long !== 1) begin errors++; $display("FAIL long_count: got %0d want 1", n_long); end
    checks++;
    if (long_at - rise_at < 17 || long_at - rise_at > 21) begin
      errors++; $display("FAIL long_latency: got %0d want 17..21", long_at - rise_at);
    end
    checks++; if (n_short + n_dbl !== 0) begin errors++; $display("FAIL long_release: got %0d want 0", n_short + n_dbl); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_busy_off: got %b want 0", busy); end
  endtask

  task automatic test_double();
    int rise2;
    apply_reset();
    cyc(1); db = 1'b1;
    cyc(4); db = 1'b0;
    cyc(4); db = 1'b1; rise2 = cyc_n + 1;
    cyc(4); db = 1'b0;
    cyc(20);
    checks++; if (n_dbl !== 1) begin errors++; $display("FAIL dbl_count: got %0d want 1", n_dbl); end
    checks++; if (dbl_at !== rise2) begin errors++; $display("FAIL dbl_cycle: got %0d want %0d", dbl_at, rise2); end
    checks++; if (n_short + n_long !== 0) begin errors++; $display("FAIL dbl_other: got %0d want 0", n_short + n_long); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dbl_busy_off: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cyc(1); db = 1'b1;
    cyc(4); db = 1'b0;
    cyc(16);
    checks++; if (n_short !== 1) begin errors++; $display("FAIL b2b_first: got %0d want 1", n_short); end
    db = 1'b1;
    cyc(4); db = 1'b0;
    cyc(20);
    checks++; if (n_short !== 2) begin errors++; $display("FAIL b2b_second: got %0d want 2", n_short); end
    checks++; if (n_dbl + n_long !== 0) begin errors++; $display("FAIL b2b_other: got %0d want 0", n_dbl + n_long); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cyc(1); db = 1'b1;
    cyc(5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({short_press, long_press, double_click, busy} !== 4'b0) begin
      errors++; $display("FAIL mid_async_clear: got %b want 0000", {short_press, long_press, double_click, busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clr_counts();
    cyc(30);
    checks++; if (n_short + n_long + n_dbl !== 0) begin errors++; $display("FAIL mid_held_pulses: got %0d want 0", n_short + n_long + n_dbl); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_held_busy: got %b want 0", busy); end
    db = 1'b0;
    cyc(2); db = 1'b1;
    cyc(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_repress_busy: got %b want 1", busy); end
    cyc(3); db = 1'b0;
    cyc(20);
    checks++; if (n_short !== 1) begin errors++; $display("FAIL mid_repress_short: got %0d want 1", n_short); end
  endtask

  // Rise at edge 2; ticks at edges 4,8,..; the fifth tick (edge 20) would
  // fire long_press, so the fall is placed on edge 20.
  task automatic test_edge_priority();
    apply_reset();
    cyc(1); db = 1'b1;
    cyc(18); db = 1'b0;
    cyc(1);
    checks++; if (cyc_n !== 20) begin errors++; $display("FAIL prio_alignment: got %0d want 20", cyc_n); end
    checks++; if (long_press !== 1'b0) begin errors++; $display("FAIL prio_no_long: got %b want 0", long_press); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_wait2_busy: got %b want 1", busy); end
    cyc(20);
    checks++; if (n_long !== 0) begin errors++; $display("FAIL prio_long_total: got %0d want 0", n_long); end
    checks++; if (n_short !== 1) begin errors++; $display("FAIL prio_short: got %0d want 1", n_short); end
  endtask

  initial begin
    cyc_n = 0;
    clr_counts();
    test_reset();
    test_short();
    test_long();
    test_double();
    test_back_to_back();
    test_reset_mid();
    test_edge_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
